// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//  Shared types and constants for the 5-stage pipeline hazard controller.
//    vec_state_t : states of the multi-cycle vector-op tracker
//    op_type_t   : hazard action selected for the current cycle
//    pipe_ctl_t  : PC enable plus the pipe-register enable/flush bundle
//    ctl_for()   : maps an action onto the enable/flush bundle
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   // Width of the vector occupancy down-counter; VEC_CYCLES may be up to 255.
   localparam int VEC_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_LAST = 2'd2
   } vec_state_t;

   // Resolved action for one cycle, highest priority first.
   typedef enum logic [2:0] {
      OP_RUN       = 3'd0,
      OP_EXT_STALL = 3'd1,
      OP_VEC_STALL = 3'd2,
      OP_BRANCH    = 3'd3,
      OP_LOAD_USE  = 3'd4
   } op_type_t;

   typedef struct packed {
      logic pc_en;
      logic en_if_id;
      logic en_id_ex;
      logic en_ex_mem;
      logic en_mem_wb;
      logic flush_if_id;
      logic flush_id_ex;
      logic flush_ex_mem;
   } pipe_ctl_t;

   localparam pipe_ctl_t PIPE_RUN = '{
      pc_en: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1, en_mem_wb: 1'b1,
      flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_ex_mem: 1'b0
   };

   function automatic pipe_ctl_t ctl_for(input op_type_t op);
      pipe_ctl_t c;
      c = PIPE_RUN;
      case (op)
         OP_EXT_STALL: begin
            // Whole pipe frozen; nothing is cleared.
            c = '0;
         end
         OP_VEC_STALL: begin
            // Keep the vector op in EX, let MEM/WB drain, feed a bubble into MEM.
            c.pc_en        = 1'b0;
            c.en_if_id     = 1'b0;
            c.en_id_ex     = 1'b0;
            c.en_ex_mem    = 1'b0;
            c.flush_ex_mem = 1'b1;
         end
         OP_BRANCH: begin
            // Squash the two wrong-path instructions behind the branch.
            c.flush_if_id = 1'b1;
            c.flush_id_ex = 1'b1;
         end
         OP_LOAD_USE: begin
            // Hold the consumer in ID for one cycle, bubble into EX.
            c.pc_en       = 1'b0;
            c.en_if_id    = 1'b0;
            c.en_id_ex    = 1'b0;
            c.flush_id_ex = 1'b1;
         end
         default: c = PIPE_RUN;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//  Saturating up-counter for hazard statistics.
//    CLK     : clock
//    RST     : synchronous active-high clear
//    inc_i   : count one event this cycle
//    hold_i  : freeze the counter (overrides inc_i)
//    count_o : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc_i,
   input  logic         hold_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_reg <= '0;
      end else if (inc_i && !hold_i && (count_reg != '1)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count_o = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//  Pipeline control for the 5-stage scalar/vector ASIP. Produces PC enable and
//  the enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers,
//  resolving (highest first) external memory stalls, multi-cycle vector ops in
//  EX, taken-branch flushes and load-use hazards. Outputs are combinational
//  from registered state plus current inputs.
//  Ports:
//    CLK, RST                     : clock, synchronous active-high reset
//    stall_i                      : memory not ready, freezes everything
//    A1_ID_i, A2_ID_i, UseA*_ID_i : ID-stage source registers and use flags
//    A3_EX_i, RegFile_WE_EX_i     : EX-stage destination and write enable
//    WBSelect_EX_i                : EX instruction is a load
//    VecMulti_EX_i                : EX holds a multi-cycle vector op
//    BranchTaken_EX_i             : branch in EX resolved taken
//    PC_enable_o, enable_*_o      : PC / pipe-register enables
//    flush_*_o                    : pipe-register bubble insertion
//    busy_o                       : vector tracker not idle
//    stall_cnt_o, flush_cnt_o     : saturating hazard statistics
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W      = 4,
   parameter int VEC_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             stall_i,
   input  logic [REG_W-1:0] A1_ID_i,
   input  logic [REG_W-1:0] A2_ID_i,
   input  logic             UseA1_ID_i,
   input  logic             UseA2_ID_i,
   input  logic [REG_W-1:0] A3_EX_i,
   input  logic             RegFile_WE_EX_i,
   input  logic             WBSelect_EX_i,
   input  logic             VecMulti_EX_i,
   input  logic             BranchTaken_EX_i,
   output logic             PC_enable_o,
   output logic             enable_IF_ID_o,
   output logic             enable_ID_EX_o,
   output logic             enable_EX_MEM_o,
   output logic             enable_MEM_WB_o,
   output logic             flush_IF_ID_o,
   output logic             flush_ID_EX_o,
   output logic             flush_EX_MEM_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // Remaining BUSY cycles loaded on entry: the entry cycle and the LAST
   // cycle are not counted, hence VEC_CYCLES-2.
   localparam int VEC_LOAD = (VEC_CYCLES > 2) ? (VEC_CYCLES - 2) : 0;

   vec_state_t           state_reg, state_next;
   logic [VEC_CNT_W-1:0] cnt_reg, cnt_next;

   op_type_t  op;
   pipe_ctl_t ctl;
   logic      load_use;
   logic      vec_stall;
   logic      stall_inc;
   logic      flush_inc;

   // ALU-to-ALU dependencies are forwarded; only a load feeding ID stalls.
   assign load_use = RegFile_WE_EX_i && WBSelect_EX_i &&
                     ((UseA1_ID_i && (A1_ID_i == A3_EX_i)) ||
                      (UseA2_ID_i && (A2_ID_i == A3_EX_i)));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      vec_stall  = 1'b0;
      op         = OP_RUN;

      if (RST) begin
         // Pipe registers clear themselves; leave them free-running.
         op = OP_RUN;
      end else if (stall_i) begin
         // Frozen: tracker holds, EX contents are re-evaluated after release.
         op = OP_EXT_STALL;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (VecMulti_EX_i && (VEC_CYCLES > 1)) begin
                  vec_stall  = 1'b1;
                  cnt_next   = VEC_CNT_W'(VEC_LOAD);
                  state_next = (VEC_CYCLES > 2) ? ST_BUSY : ST_LAST;
               end
            end
            ST_BUSY: begin
               vec_stall = 1'b1;
               cnt_next  = cnt_reg - VEC_CNT_W'(1);
               if (cnt_reg == VEC_CNT_W'(1)) begin
                  state_next = ST_LAST;
               end
            end
            ST_LAST: begin
               // Final EX cycle of the op; it advances to MEM at this edge.
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase

         if (vec_stall) begin
            op = OP_VEC_STALL;
         end else if (BranchTaken_EX_i) begin
            op = OP_BRANCH;
         end else if (load_use) begin
            op = OP_LOAD_USE;
         end
      end
   end

   assign ctl       = ctl_for(op);
   assign stall_inc = (op == OP_VEC_STALL) || (op == OP_LOAD_USE);
   assign flush_inc = (op == OP_BRANCH);

   assign PC_enable_o     = ctl.pc_en;
   assign enable_IF_ID_o  = ctl.en_if_id;
   assign enable_ID_EX_o  = ctl.en_id_ex;
   assign enable_EX_MEM_o = ctl.en_ex_mem;
   assign enable_MEM_WB_o = ctl.en_mem_wb;
   assign flush_IF_ID_o   = ctl.flush_if_id;
   assign flush_ID_EX_o   = ctl.flush_id_ex;
   assign flush_EX_MEM_o  = ctl.flush_ex_mem;
   assign busy_o          = (state_reg != ST_IDLE);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK     (CLK),
      .RST     (RST),
      .inc_i   (stall_inc),
      .hold_i  (stall_i),
      .count_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK     (CLK),
      .RST     (RST),
      .inc_i   (flush_inc),
      .hold_i  (stall_i),
      .count_o (flush_cnt_o)
   );

endmodule
